// File: rtl/updown_counter_param.sv
// Parametrised up/down modulo counter.
// Adds load, enable, wrap/saturate, terminal count and wrap pulse.
module updown_counter_param #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Reject widths and moduli the counter cannot represent.
  if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
    $error("updown_counter_param: illegal WIDTH/MODULUS");
  end

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic at_top;
  logic at_zero;
  logic din_ok;

  // End detection and load range check on current state and inputs.
  always_comb begin
    at_top  = (q == TOP);
    at_zero = (q == '0);
    din_ok  = ({1'b0, din} < MOD_EXT);
  end

  // Terminal count feeds a cascaded stage's enable.
  assign tc = en & (mode ? at_top : at_zero);

  // Count state: clear beats load beats step beats hold.
  always_ff @(posedge clk) begin
    if (clear) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= din_ok ? din : TOP;
      wrap <= 1'b0;
    end else if (en) begin
      if (mode) begin
        if (!at_top) begin
          q    <= q + ONE;
          wrap <= 1'b0;
        end else if (!sat) begin
          q    <= '0;
          wrap <= 1'b1;
        end else begin
          wrap <= 1'b0;
        end
      end else begin
        if (!at_zero) begin
          q    <= q - ONE;
          wrap <= 1'b0;
        end else if (!sat) begin
          q    <= TOP;
          wrap <= 1'b1;
        end else begin
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param.
// Two instances: 3-bit mod 8 and 4-bit mod 10.
module tb_updown_counter_param;

  typedef struct {
    logic       clear;
    logic       load;
    logic       en;
    logic       mode;
    logic       sat;
    logic [3:0] din;
    logic       chk_tc;
    logic       tc;
    logic [3:0] q;
    logic       wrap;
  } vec_t;

  typedef struct {
    int         sel;
    logic [3:0] q;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear8 = 1'b0, en8 = 1'b0, mode8 = 1'b0;
  logic       load8 = 1'b0, sat8 = 1'b0;
  logic [2:0] din8 = '0;
  logic [2:0] q8;
  logic       tc8, wrap8;

  logic       clear10 = 1'b0, en10 = 1'b0, mode10 = 1'b0;
  logic       load10 = 1'b0, sat10 = 1'b0;
  logic [3:0] din10 = '0;
  logic [3:0] q10;
  logic       tc10, wrap10;

  updown_counter_param #(.WIDTH(3), .MODULUS(8)) u8 (
    .clk(clk), .clear(clear8), .en(en8), .mode(mode8),
    .load(load8), .din(din8), .sat(sat8),
    .q(q8), .tc(tc8), .wrap(wrap8)
  );

  updown_counter_param #(.WIDTH(4), .MODULUS(10)) u10 (
    .clk(clk), .clear(clear10), .en(en10), .mode(mode10),
    .load(load10), .din(din10), .sat(sat10),
    .q(q10), .tc(tc10), .wrap(wrap10)
  );

  int   total = 0;
  int   fails = 0;
  int   step_no = 0;
  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(
    logic cl, logic ld, logic e, logic m, logic s,
    logic [3:0] d, logic ct, logic t, logic [3:0] eq, logic ew
  );
    vec_t v;
    v.clear = cl; v.load = ld; v.en = e; v.mode = m; v.sat = s;
    v.din = d; v.chk_tc = ct; v.tc = t; v.q = eq; v.wrap = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      fails++;
      $display("FAIL %s step %0d: got %0d want %0d", nm, step_no, act, req);
    end
  endtask

  task automatic apply(input int sel, input vec_t v);
    exp_t e, g;
    @(negedge clk);
    step_no++;
    if (sel == 8) begin
      clear8 = v.clear; load8 = v.load; en8 = v.en;
      mode8 = v.mode; sat8 = v.sat; din8 = v.din[2:0];
    end else begin
      clear10 = v.clear; load10 = v.load; en10 = v.en;
      mode10 = v.mode; sat10 = v.sat; din10 = v.din;
    end
    #1;
    if (v.chk_tc)
      chk("tc", int'(sel == 8 ? tc8 : tc10), int'(v.tc));
    e.sel = sel; e.q = v.q; e.wrap = v.wrap;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      g = sb.pop_front();
      if (g.sel == 8) begin
        chk("q8", int'(q8), int'(g.q));
        chk("wrap8", int'(wrap8), int'(g.wrap));
      end else begin
        chk("q10", int'(q10), int'(g.q));
        chk("wrap10", int'(wrap10), int'(g.wrap));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    // mod-10 vectors: clear, down-wrap, saturation, load, clear, hold, flip
    tbl.push_back(mk(1,0,0,0,0, 0, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 1,0, 0,0));
    tbl.push_back(mk(0,0,1,0,0, 0, 1,1, 9,1));
    for (int k = 8; k >= 0; k--)
      tbl.push_back(mk(0,0,1,0,0, 0, 1,0, 4'(k),0));
    tbl.push_back(mk(0,0,1,0,0, 0, 1,1, 9,1));
    tbl.push_back(mk(1,0,1,0,0, 0, 1,0, 0,0));
    tbl.push_back(mk(0,0,1,0,0, 0, 1,1, 9,1));
    tbl.push_back(mk(0,0,1,0,0, 0, 1,0, 8,0));
    tbl.push_back(mk(0,1,1,1,1, 8, 1,0, 8,0));
    tbl.push_back(mk(0,0,1,1,1, 0, 1,0, 9,0));
    tbl.push_back(mk(0,0,1,1,1, 0, 1,1, 9,0));
    tbl.push_back(mk(0,0,1,1,1, 0, 1,1, 9,0));
    tbl.push_back(mk(0,0,1,0,1, 0, 1,0, 8,0));
    tbl.push_back(mk(0,1,1,1,0, 5, 1,0, 5,0));
    tbl.push_back(mk(0,1,0,1,0, 12, 1,0, 9,0));
    tbl.push_back(mk(0,0,1,1,0, 0, 1,1, 0,1));
    tbl.push_back(mk(0,1,0,1,0, 6, 1,0, 6,0));
    tbl.push_back(mk(1,1,1,1,0, 3, 1,0, 0,0));
    tbl.push_back(mk(0,0,1,1,0, 0, 1,0, 1,0));
    tbl.push_back(mk(0,1,0,1,0, 4, 1,0, 4,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0,0,1,0, 0, 1,0, 4,0));
    tbl.push_back(mk(0,0,1,1,0, 0, 1,0, 5,0));
    tbl.push_back(mk(0,0,1,0,0, 0, 1,0, 4,0));
    tbl.push_back(mk(0,0,1,1,0, 0, 1,0, 5,0));
    tbl.push_back(mk(0,0,1,0,0, 0, 1,0, 4,0));

    foreach (tbl[i]) apply(10, tbl[i]);

    // mod-8: reset then full up-count with natural wrap
    apply(8, mk(1,0,0,0,0, 0, 0,0, 0,0));
    for (int i = 1; i <= 9; i++)
      apply(8, mk(0,0,1,1,0, 0, 1,
                  logic'(((i - 1) % 8) == 7),
                  4'(i % 8), logic'(i == 8)));
    // mod-8: down through zero wraps to 7
    apply(8, mk(0,0,1,0,0, 0, 1,0, 0,0));
    apply(8, mk(0,0,1,0,0, 0, 1,1, 7,1));
    apply(8, mk(0,0,0,0,0, 0, 1,0, 7,0));

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised synchronous up/down counter: the next generation of the team's 3-bit up/down counter, generalised to any width and modulus. Adds count enable, parallel load, wrap-or-saturate end behaviour, terminal-count output and a registered wrap pulse. Sits in the lab datapath wherever a programmable modulo counter, address sequencer or bidirectional event counter is needed.

## Interface

Parameters:
- WIDTH, default 3: counter width in bits; minimum 1.
- MODULUS, default 2**WIDTH: count range 0..MODULUS-1; legal range 2..2**WIDTH. Outside that range is an elaboration error.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- clear  input  1  reset, synchronous, active-high; takes effect on the rising clk edge.
- en  input  1  count enable; 1 = step one count this edge.
- mode  input  1  direction; 1 = up, 0 = down.
- load  input  1  parallel load strobe.
- din  input  WIDTH  load value.
- sat  input  1  end behaviour; 1 = saturate at the ends, 0 = wrap modulo MODULUS.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: en & (mode ? q==MODULUS-1 : q==0).
- wrap  output  1  registered one-cycle pulse; 1 in the cycle after a wrap occurred.

## Operation

- Priority per rising edge: clear > load > en > hold.
- clear=1: q <= 0, wrap <= 0; all other inputs ignored.
- load=1: q <= din if din < MODULUS, otherwise q <= MODULUS-1 (clamp). wrap <= 0. en ignored.
- en=1, mode=1 (up):
  - q < MODULUS-1: q <= q+1.
  - q == MODULUS-1, sat=0: q <= 0, wrap <= 1.
  - q == MODULUS-1, sat=1: q holds, wrap <= 0.
- en=1, mode=0 (down):
  - q > 0: q <= q-1.
  - q == 0, sat=0: q <= MODULUS-1, wrap <= 1.
  - q == 0, sat=1: q holds, wrap <= 0.
- en=0, no load/clear: q holds, wrap <= 0.
- Arithmetic is unsigned WIDTH-bit. The modulo compare is explicit, never implicit overflow, so non-power-of-two MODULUS works. When MODULUS == 2**WIDTH, results equal natural WIDTH-bit wrap.
- mode, sat and en may change on any cycle. The new values apply at the next edge. There is no direction-change penalty.
- tc depends only on the current q, en and mode. It is usable as the enable of a cascaded counter stage.

## Timing

- Reset values: q = 0 and wrap = 0, valid from the first edge with clear=1. After reset, tc = en & ~mode.
- Latency:
  - Count or load is visible on q one cycle after the edge that samples it.
  - wrap is asserted in the same cycle that q shows the wrapped value, for exactly one cycle unless another wrap follows.
- Back-to-back wraps pulse wrap on every wrapping edge. Example: MODULUS=2 with en held asserts wrap every second cycle.
- clear asserted mid-count overrides a simultaneous load or en on the same edge. Counting resumes from 0 on the first edge after clear deasserts.
- load and en on the same edge: load wins, no step occurs, no wrap pulse.
- tc is combinational from registered q and the live en/mode inputs. There is no path from din or load to tc.

## Test plan

- Reset and up-count, WIDTH=3, MODULUS=8, sat=0, mode=1, en=1: q steps 0,1,…,7,0. wrap=1 only in the cycle q returns to 0. tc=1 while q=7.
- Down-count with non-power-of-two modulus, WIDTH=4, MODULUS=10, mode=0, en=1 from q=0: q goes 9,8,…,0,9. wrap=1 on each 0→9 transition. tc=1 while q=0. q never exceeds 9.
- Saturation, MODULUS=10, sat=1: up from 8 gives 9,9,9 with wrap=0. Switch to mode=0 at q=9: the next edge gives q=8.
- Load:
  - load=1, din=5, with en=1 on the same edge: q=5 next cycle, no step, wrap=0.
  - din=12 with MODULUS=10: q=9 (clamp).
- Clear priority: assert clear together with load=1, din=3 at q=6: q=0 next cycle and wrap=0. Deassert clear with en=1, mode=1: q=1 on the following edge.
- Hold and direction flip:
  - en=0 for 4 cycles at q=4: q stays 4, wrap=0, tc=0.
  - Alternate mode every cycle with en=1 from q=4: q toggles 5,4,5,4.
